// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation
// encodings, FSM state encodings, latency and small op-decode helpers.
package muldiv_unit_pkg;

    localparam int MD_XLEN    = 32;
    localparam int MD_LATENCY = MD_XLEN + 2;

    // Operation encodings (op input)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // FSM state encodings
    localparam logic [2:0] MD_ST_IDLE = 3'd0;
    localparam logic [2:0] MD_ST_PREP = 3'd1;
    localparam logic [2:0] MD_ST_RUN  = 3'd2;
    localparam logic [2:0] MD_ST_FIX  = 3'd3;
    localparam logic [2:0] MD_ST_DONE = 3'd4;

    // Signed ops have op[0] clear (MULT, DIV)
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Divide ops have op[1] set (DIV, DIVU)
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control/register-file side (master)
// and the multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic                start;
    logic [1:0]          op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic                busy;
    logic [2*XLEN-1:0]   lohi_data;
    logic                WriteLoHi;
    logic                div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, lohi_data, WriteLoHi, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, lohi_data, WriteLoHi, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit_twos_neg.sv
// Conditional two's-complement negate: o_val = i_en ? -i_val : i_val.
// Used for operand magnitudes and for result sign correction.
module twos_neg #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_en ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing the 64-bit hi/lo result
// for MULT, MULTU, DIV and DIVU with a start/busy handshake.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    logic [2:0]        r_state;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_a;        // original dividend/multiplicand, kept for div-by-zero hi
    logic [XLEN-1:0]   r_b;        // raw b on accept, magnitude of b from PREP onwards
    logic [XLEN-1:0]   r_hi;       // partial product high half / partial remainder
    logic [XLEN-1:0]   r_lo;       // multiplier being shifted out / dividend becoming quotient
    logic              r_neg_lo;   // negate product (mult) or quotient (div)
    logic              r_neg_hi;   // negate remainder (signed div with negative a)
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_wr;
    logic              r_dbz;
    logic [2*XLEN-1:0] r_result;

    logic              w_prep;
    logic              w_x_en, w_y_en;
    logic [XLEN-1:0]   w_x_in, w_y_in, w_neg_x, w_neg_y;
    logic [2*XLEN-1:0] w_neg_p;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [XLEN-1:0]   w_step_hi, w_step_lo;
    logic              w_dbz;
    logic [2*XLEN-1:0] w_fix;

    // Share the two 32-bit negators: operand magnitudes in PREP, quotient/remainder sign fix in FIX
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_prep = (r_state == MD_ST_PREP);
        w_x_en = r_neg_lo;
        w_x_in = r_lo;
        w_y_en = r_neg_hi;
        w_y_in = r_hi;
        if (w_prep) begin
            w_x_en = md_is_signed(r_op) & r_a[XLEN-1];
            w_x_in = r_a;
            w_y_en = md_is_signed(r_op) & r_b[XLEN-1];
            w_y_in = r_b;
        end
    end

    twos_neg #(.WIDTH(XLEN)) u_neg_x (
        .i_en  (w_x_en),
        .i_val (w_x_in),
        .o_val (w_neg_x)
    );

    twos_neg #(.WIDTH(XLEN)) u_neg_y (
        .i_en  (w_y_en),
        .i_val (w_y_in),
        .o_val (w_neg_y)
    );

    twos_neg #(.WIDTH(2*XLEN)) u_neg_p (
        .i_en  (r_neg_lo),
        .i_val ({r_hi, r_lo}),
        .o_val (w_neg_p)
    );

    // One radix-2 step (shift-add or restoring shift-subtract) and the FIX-stage result mux
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
        // Low bits suffice: when w_ge holds the true difference is below the divisor.
        w_sub   = w_shift[XLEN-1:0] - r_b;
        if (md_is_div(r_op)) begin
            w_step_hi = w_ge ? w_sub : w_shift[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_step_hi = w_sum[XLEN:1];
            w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end

        w_dbz = md_is_div(r_op) & (r_b == '0);
        if (!md_is_div(r_op))
            w_fix = w_neg_p;
        else if (w_dbz)
            w_fix = {r_a, {XLEN{1'b1}}};
        else
            w_fix = {w_neg_y, w_neg_x};
    end

    // Control FSM and datapath registers
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= MD_ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_wr     <= 1'b0;
            r_dbz    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                MD_ST_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_busy  <= 1'b1;
                        r_state <= MD_ST_PREP;
                    end
                end
                MD_ST_PREP: begin
                    r_lo     <= w_neg_x;
                    r_b      <= w_neg_y;
                    r_hi     <= '0;
                    r_cnt    <= '0;
                    r_neg_lo <= md_is_signed(r_op) & (r_a[XLEN-1] ^ r_b[XLEN-1]);
                    r_neg_hi <= md_is_signed(r_op) & md_is_div(r_op) & r_a[XLEN-1];
                    r_state  <= MD_ST_RUN;
                end
                MD_ST_RUN: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN-1))
                        r_state <= MD_ST_FIX;
                end
                MD_ST_FIX: begin
                    r_result <= w_fix;
                    r_dbz    <= w_dbz;
                    r_wr     <= 1'b1;
                    r_state  <= MD_ST_DONE;
                end
                MD_ST_DONE: begin
                    r_wr    <= 1'b0;
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MD_ST_IDLE;
                end
                default: r_state <= MD_ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.lohi_data   = r_result;
    assign bus.WriteLoHi   = r_wr;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, strike
// width, div-by-zero, start-while-busy and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // glitch: 0 none, 1 second start mid-RUN, 2 start during DONE
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input logic exp_dbz,
                          input int glitch);
        int k;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = b + 32'd1;
        check({tag, " busy_rise"}, 64'(bus.busy), 64'd1);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (glitch == 1 && k == 10) begin
                bus.start = 1'b1;
                bus.op    = MD_DIVU;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
            end
            if (glitch == 1 && k == 11) bus.start = 1'b0;
            if (bus.WriteLoHi) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(k), 64'd34);
        check({tag, " data"}, bus.lohi_data, exp);
        check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        check({tag, " busy_done"}, 64'(bus.busy), 64'd1);
        if (glitch == 2) begin
            bus.start = 1'b1;
            bus.op    = MD_MULTU;
            bus.a     = 32'd5;
            bus.b     = 32'd5;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " strike_low"}, 64'(bus.WriteLoHi), 64'd0);
        check({tag, " dbz_low"}, 64'(bus.div_by_zero), 64'd0);
        check({tag, " busy_fall"}, 64'(bus.busy), 64'd0);
        check({tag, " hold"}, bus.lohi_data, exp);
        @(posedge clk);
        #1;
        check({tag, " idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int strikes;
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst strike", 64'(bus.WriteLoHi), 64'd0);
        check("rst dbz", 64'(bus.div_by_zero), 64'd0);
        check("rst data", bus.lohi_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 0);
        run_op("mult_neg3x7", MD_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 0);
        run_op("mult_minmin", MD_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 0);
        run_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 0);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 0);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 2);
        run_op("divu_by0", MD_DIVU, 32'h00001234, 32'd0, 64'h00001234_FFFFFFFF, 1'b1, 0);
        run_op("div_m7_by0", MD_DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1, 0);
        run_op("multu_glitch", MD_MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0, 1);
        run_op("div_min_m1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 0);

        // Abort an operation at RUN step 10 with reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'h0000FFFF;
        bus.b     = 32'h0000FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort strike", 64'(bus.WriteLoHi), 64'd0);
        check("abort dbz", 64'(bus.div_by_zero), 64'd0);
        check("abort data", bus.lohi_data, 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        strikes = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.WriteLoHi) strikes++;
        end
        check("abort no_strike", 64'(strikes), 64'd0);
        check("abort idle", 64'(bus.busy), 64'd0);

        run_op("multu_3x5", MD_MULTU, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
